instr_fetch: RTL

Instruction fetch stage sitting directly downstream of the 256×16 program SRAM. It drives the SRAM's chip-select, read and address pins, and captures the registered `DOUT` when `is_coming` is high. Each captured word is paired with its PC and buffered in a small FIFO. Instructions go to decode over a valid/ready handshake, with support for branch redirect, fetch enable and back-pressure.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 91 +++++++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared defaults for the fetch path: address/data widths,
//               reset PC, buffer depth and the {pc, data} packing of an
//               instruction buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned C_ADDR_W     = 8;
  localparam int unsigned C_DATA_W     = 16;
  localparam int unsigned C_FIFO_DEPTH = 2;
  localparam logic [C_ADDR_W-1:0] C_RESET_PC = 8'h00;

  // Buffer entry layout: PC in the upper bits, instruction word in the lower.
  localparam int unsigned C_ENTRY_W = C_ADDR_W + C_DATA_W;

  typedef struct packed {
    logic [C_ADDR_W-1:0] pc;
    logic [C_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small circular instruction buffer. Power-of-two depth so the
//               pointers wrap naturally. Flush empties the buffer and takes
//               precedence over push/pop in the same cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push/push_data- write an entry (ignored when full)
//               pop           - consume the head entry (ignored when empty)
//               flush         - discard all entries
//               full, empty   - occupancy flags
//               count         - number of stored entries
//               head          - entry at the read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == C_DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop in the flush cycle has already been taken by the consumer;
      // resetting the pointers covers both.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage in front of a 1-cycle-latency program
//               SRAM. Issues reads only when the buffer has room for the
//               returning word (credit = buffered + in-flight), pairs each
//               returned word with its PC and presents it to decode over a
//               valid/ready handshake. Supports redirect and fetch enable.
// Ports       : clk, rst                  - clock, sync active-high reset
//               fetch_en                  - permit new SRAM reads
//               redirect_valid/_pc        - taken branch, new fetch address
//               mem_cs_n/rd/wd/addr       - SRAM control and address
//               mem_dout/mem_valid        - SRAM read data and its valid
//               inst_valid/ready/data/pc  - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W     = C_ADDR_W,
  parameter int unsigned        DATA_W     = C_DATA_W,
  parameter int unsigned        FIFO_DEPTH = C_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_PC   = C_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_cs_n,
  output logic              mem_rd,
  output logic              mem_wd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_valid,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]     occupancy;
  logic               space;
  logic               issue;

  // Every issued read owns a buffer slot from issue until it is popped,
  // so the buffer can never overflow even though data lags by a cycle.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
  assign fifo_pop  = inst_valid & inst_ready;
  assign space     = (occupancy < C_DEPTH) || ((occupancy == C_DEPTH) && fifo_pop);
  assign issue     = ~rst & fetch_en & ~redirect_valid & space;

  assign mem_rd    = issue;
  assign mem_cs_n  = ~issue;
  assign mem_wd    = 1'b0;
  assign mem_addr  = pc_q;

  // A response landing in a redirect cycle belongs to the old path.
  assign fifo_push = mem_valid & inflight_q & ~redirect_valid;

  assign inst_valid = ~fifo_empty;
  assign inst_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign inst_data  = fifo_head[DATA_W-1:0];

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({inflight_pc_q, mem_dout}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full))
        else $error("instr_fetch: buffer push while full");
    end
  end
`endif

endmodule
`default_nettype wire
